src_arbiter: RTL and testbench
==============================

SRC_ARBITER -- requirements
Module: src_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, flit data width.
REQ-002 Parameter N, default 16, number of NoC nodes.
REQ-003 Parameter N_ADDR_WIDTH, default $clog2(N), destination address width.
REQ-004 Parameter K, default 4, number of requesting traffic sources, range 2..16.
REQ-005 Parameter BURST, default 4, maximum consecutive grants to one requester, minimum 1.
REQ-006 clk  input  1  clock.
REQ-007 rst  input  1  reset: synchronous, active-high.
REQ-008 req_data  input  K x WIDTH  per-requester flit.
REQ-009 req_dest  input  K x N_ADDR_WIDTH  per-requester destination node.
REQ-010 req_valid  input  K  per-requester flit valid.
REQ-011 req_ready  output  K  per-requester accept; one-hot or zero.
REQ-012 out_data  output  WIDTH  flit to NoC node port.
REQ-013 out_dest  output  N_ADDR_WIDTH  destination to NoC node port.
REQ-014 out_valid  output  1  output flit valid.
REQ-015 out_ready  input  1  NoC node port accepts flit.

Function
REQ-016 A transfer from requester i SHALL occur on a clock edge where req_valid[i] and req_ready[i] are both high, and an output transfer SHALL occur where out_valid and out_ready are both high.
REQ-017 The block SHALL hold one output register (out_data, out_dest, out_valid); the slot is free when out_valid is low or an output transfer occurs in the same cycle.
REQ-018 req_ready SHALL be combinational: high only for the granted requester, and only when the slot is free and rst is low.
REQ-019 A requester transfer SHALL load its flit and destination into the output register, with out_valid high the next cycle (1-cycle latency) and data unmodified.
REQ-020 While out_valid is high and out_ready is low, out_data, out_dest, and out_valid SHALL remain stable.
REQ-021 When the slot is free and no requester transfer occurs, out_valid SHALL go low at the next edge.
REQ-022 The state machine SHALL have states IDLE and HOLD, with owner index and burst counter cnt (0..BURST).
REQ-023 In IDLE, the grant SHALL be the first valid requester, searching upward from pointer ptr and wrapping from K-1 to 0.
REQ-024 On a transfer in IDLE, the FSM SHALL set owner=grant and cnt=1, then enter HOLD if BURST>1, or stay in IDLE with ptr=(grant+1) mod K.
REQ-025 In HOLD, the grant SHALL be owner only.
REQ-026 In HOLD, a transfer SHALL increment cnt; when cnt reaches BURST, the FSM SHALL return to IDLE with ptr=(owner+1) mod K.
REQ-027 In HOLD, if req_valid[owner] is low while the slot is free, the FSM SHALL return to IDLE with ptr=(owner+1) mod K, with no grant that cycle.
REQ-028 When the slot is not free, the FSM state, cnt, and ptr SHALL not change.
REQ-029 Round-robin order SHALL guarantee that every continuously valid requester is granted within (K-1)*BURST+1 output transfers.

Reset
REQ-030 On rst: out_valid=0, out_data=0, out_dest=0, state=IDLE, ptr=0, owner=0, cnt=0, req_ready=0.
REQ-031 Assertion of rst mid-burst or with a stalled output flit SHALL discard that flit, and the first post-reset grant SHALL start at ptr=0.

Configuration
REQ-032 With macro SRC_ARBITER_STATS_EN defined, the block SHALL add input stat_sel ($clog2(K) bits) and output stat_count (16 bits).
REQ-033 Under SRC_ARBITER_STATS_EN, the block SHALL keep one saturating 16-bit grant counter per requester, reset to 0 and incremented on each transfer from that requester.
REQ-034 Under SRC_ARBITER_STATS_EN, stat_count SHALL present the counter selected by stat_sel combinationally.
REQ-035 Without SRC_ARBITER_STATS_EN, neither those ports nor the counters SHALL exist, and arbitration behaviour SHALL be identical.

Structure
REQ-036 The FSM state enum (IDLE, HOLD) SHALL reside in shared package noc_pkg.
REQ-037 Shared package noc_pkg SHALL also define the stats counter width constant (16).
REQ-038 Sub-module rr_pick SHALL implement the combinational round-robin selector, taking valid vector and ptr and producing grant index and found flag; all sequential logic stays in src_arbiter.

Verification
REQ-039 K=4, BURST=1, all valid, out_ready=1 -> grant order 0,1,2,3,0 on consecutive cycles; one flit per cycle.
REQ-040 K=4, BURST=4, all valid -> four flits from 0, then four from 1; a drop of req_valid[1] after 2 flits -> immediate move to requester 2.
REQ-041 Output flit 0xA5A5A5A5, dest 7, out_ready=0 for 5 cycles -> out_data/out_dest stable; all req_ready=0; delivered once when out_ready=1.
REQ-042 Only requester 3 valid, ptr=0 -> grant 3 in the first cycle; ptr becomes 0 after the burst; rst during HOLD with a stalled flit -> out_valid=0 next cycle, first grant to the lowest valid index.
REQ-043 SRC_ARBITER_STATS_EN, 70000 transfers from requester 2 -> stat_count with stat_sel=2 saturates at 65535; other counters stay 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: arbiter FSM state encoding and stats counter width.
package noc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    localparam int STAT_W = 16;

endpackage

// File: rtl/src_arbiter_if.sv
// Requester-side and NoC-port-side flit handshakes of src_arbiter, grouped as one bundle.
interface src_arbiter_if #(
    parameter int WIDTH        = 32,
    parameter int N_ADDR_WIDTH = 4,
    parameter int K            = 4
);
    logic [K-1:0][WIDTH-1:0]        req_data;
    logic [K-1:0][N_ADDR_WIDTH-1:0] req_dest;
    logic [K-1:0]                   req_valid;
    logic [K-1:0]                   req_ready;
    logic [WIDTH-1:0]               out_data;
    logic [N_ADDR_WIDTH-1:0]        out_dest;
    logic                           out_valid;
    logic                           out_ready;

    // Environment side: sources drive flits, the node port drives out_ready.
    modport master (
        output req_data, req_dest, req_valid, out_ready,
        input  req_ready, out_data, out_dest, out_valid
    );

    // Arbiter side.
    modport slave (
        input  req_data, req_dest, req_valid, out_ready,
        output req_ready, out_data, out_dest, out_valid
    );
endinterface

// File: rtl/src_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of valid at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int K  = 4,
    parameter int IW = $clog2(K)
) (
    input  logic [K-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          found
);
    int          idx_i;
    logic [IW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx_i = 0;
        idx   = '0;
        for (int i = 0; i < K; i++) begin
            idx_i = int'(ptr) + i;
            if (idx_i >= K) idx_i = idx_i - K;
            idx = IW'(idx_i);
            if (!found && valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end
endmodule

// File: rtl/src_arbiter.sv
// K-source burst round-robin arbiter feeding one registered NoC node port.
// Optional per-requester grant counters under macro SRC_ARBITER_STATS_EN.
module src_arbiter
    import noc_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int N            = 16,
    parameter int N_ADDR_WIDTH = $clog2(N),
    parameter int K            = 4,
    parameter int BURST        = 4
) (
    input  logic              clk,
    input  logic              rst,
    src_arbiter_if.slave      bus
`ifdef SRC_ARBITER_STATS_EN
    ,
    input  logic [$clog2(K)-1:0] stat_sel,
    output logic [STAT_W-1:0]    stat_count
`endif
);
    localparam int IW = $clog2(K);
    localparam int CW = $clog2(BURST + 1);

    if (K < 2 || K > 16 || BURST < 1 || N < 2) begin : g_bad_cfg
        $error("src_arbiter: unsupported parameter set");
    end

    arb_state_e    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic [CW-1:0] cnt;

    logic [IW-1:0] rr_grant;
    logic          rr_found;
    logic [IW-1:0] grant;
    logic          grant_ok;
    logic          slot_free;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        if (int'(i) == K - 1) return '0;
        return i + 1'b1;
    endfunction

    rr_pick #(.K(K), .IW(IW)) u_pick (
        .valid (bus.req_valid),
        .ptr   (ptr),
        .grant (rr_grant),
        .found (rr_found)
    );

    // While holding, only the burst owner may be granted; otherwise round-robin.
    always_comb begin
        slot_free = !bus.out_valid || bus.out_ready;
        if (state == HOLD) begin
            grant    = owner;
            grant_ok = bus.req_valid[owner];
        end else begin
            grant    = rr_grant;
            grant_ok = rr_found;
        end
    end

    assign bus.req_ready = (slot_free && grant_ok && !rst) ? (K'(1) << grant) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            owner         <= '0;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_dest  <= '0;
        end else if (slot_free) begin
            bus.out_valid <= grant_ok;
            if (grant_ok) begin
                bus.out_data <= bus.req_data[grant];
                bus.out_dest <= bus.req_dest[grant];
            end
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        owner <= grant;
                        cnt   <= CW'(1);
                        if (BURST > 1) state <= HOLD;
                        else           ptr   <= wrap_inc(grant);
                    end
                end
                HOLD: begin
                    // Burst ends on the BURST-th flit or as soon as the owner goes idle.
                    if (grant_ok) begin
                        cnt <= cnt + 1'b1;
                        if (int'(cnt) + 1 >= BURST) begin
                            state <= IDLE;
                            ptr   <= wrap_inc(owner);
                        end
                    end else begin
                        state <= IDLE;
                        ptr   <= wrap_inc(owner);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SRC_ARBITER_STATS_EN
    logic [STAT_W-1:0] grant_cnt [K];
    logic              xfer;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        if (&v) return v;
        return v + 1'b1;
    endfunction

    assign xfer = slot_free && grant_ok && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) grant_cnt[i] <= '0;
        end else if (xfer) begin
            grant_cnt[grant] <= sat_inc(grant_cnt[grant]);
        end
    end

    assign stat_count = (int'(stat_sel) < K) ? grant_cnt[stat_sel] : '0;
`endif
endmodule

// File: tb/tb_src_arbiter.sv
// Bench for src_arbiter: BURST=1 and BURST=4 instances share stimulus, checked against a flit-level model.
module tb_src_arbiter;
    localparam int WIDTH = 32;
    localparam int N     = 16;
    localparam int NAW   = 4;
    localparam int K     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [K-1:0]            rv;
    logic [K-1:0][WIDTH-1:0] rd;
    logic [K-1:0][NAW-1:0]   rdst;
    logic                    ordy;

    src_arbiter_if #(.WIDTH(WIDTH), .N_ADDR_WIDTH(NAW), .K(K)) if1 ();
    src_arbiter_if #(.WIDTH(WIDTH), .N_ADDR_WIDTH(NAW), .K(K)) if4 ();

    assign if1.req_valid = rv;
    assign if1.req_data  = rd;
    assign if1.req_dest  = rdst;
    assign if1.out_ready = ordy;
    assign if4.req_valid = rv;
    assign if4.req_data  = rd;
    assign if4.req_dest  = rdst;
    assign if4.out_ready = ordy;

`ifdef SRC_ARBITER_STATS_EN
    logic [1:0]  ssel;
    logic [15:0] scnt1, scnt4;
`endif

    src_arbiter #(.WIDTH(WIDTH), .N(N), .N_ADDR_WIDTH(NAW), .K(K), .BURST(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
`ifdef SRC_ARBITER_STATS_EN
        , .stat_sel (ssel), .stat_count (scnt1)
`endif
    );

    src_arbiter #(.WIDTH(WIDTH), .N(N), .N_ADDR_WIDTH(NAW), .K(K), .BURST(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
`ifdef SRC_ARBITER_STATS_EN
        , .stat_sel (ssel), .stat_count (scnt4)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Flit-level reference: index 0 models BURST=1, index 1 models BURST=4.
    int          bur [2] = '{1, 4};
    bit          m_hold [2];
    int          m_owner [2];
    int          m_cnt [2];
    int          m_ptr [2];
    bit          m_ov [2];
    logic [31:0] m_od [2];
    logic [3:0]  m_odst [2];
    int          obs_g [2];

    function automatic void model_reset(int d);
        m_hold[d]  = 1'b0;
        m_owner[d] = 0;
        m_cnt[d]   = 0;
        m_ptr[d]   = 0;
        m_ov[d]    = 1'b0;
        m_od[d]    = '0;
        m_odst[d]  = '0;
    endfunction

    function automatic int model_pick(int d);
        if (m_ov[d] && !ordy) return -1;
        if (m_hold[d]) return rv[m_owner[d]] ? m_owner[d] : -1;
        for (int i = 0; i < K; i++) begin
            int j;
            j = (m_ptr[d] + i) % K;
            if (rv[j]) return j;
        end
        return -1;
    endfunction

    task automatic rand_flits();
        for (int i = 0; i < K; i++) begin
            rd[i]   = $urandom;
            rdst[i] = NAW'($urandom_range(0, 15));
        end
    endtask

    // Compare both DUTs against the model for the current cycle, then advance one clock.
    task automatic cycle();
        #1;
        for (int d = 0; d < 2; d++) begin
            int          g;
            bit          free;
            logic [K-1:0] er, ar;
            logic        ov;
            logic [31:0] od;
            logic [3:0]  odst;
            g    = model_pick(d);
            free = !m_ov[d] || ordy;
            er   = (!rst && g >= 0) ? (K'(1) << g) : '0;
            ar   = (d == 0) ? if1.req_ready : if4.req_ready;
            ov   = (d == 0) ? if1.out_valid : if4.out_valid;
            od   = (d == 0) ? if1.out_data  : if4.out_data;
            odst = (d == 0) ? if1.out_dest  : if4.out_dest;
            obs_g[d] = -1;
            for (int j = 0; j < K; j++) if (ar[j]) obs_g[d] = j;

            tests++;
            if (ar !== er) begin
                fails++;
                $display("FAIL req_ready dut%0d t=%0t: got %b want %b", d, $time, ar, er);
            end
            tests++;
            if (ov !== m_ov[d] || (m_ov[d] && (od !== m_od[d] || odst !== m_odst[d]))) begin
                fails++;
                $display("FAIL out_flit dut%0d t=%0t: got v=%b d=%h a=%0d want v=%b d=%h a=%0d",
                         d, $time, ov, od, odst, m_ov[d], m_od[d], m_odst[d]);
            end

            if (rst) begin
                model_reset(d);
            end else if (free) begin
                if (m_hold[d]) begin
                    if (g >= 0) begin
                        m_cnt[d]++;
                        if (m_cnt[d] == bur[d]) begin
                            m_hold[d] = 1'b0;
                            m_ptr[d]  = (m_owner[d] + 1) % K;
                        end
                    end else begin
                        m_hold[d] = 1'b0;
                        m_ptr[d]  = (m_owner[d] + 1) % K;
                    end
                end else if (g >= 0) begin
                    m_owner[d] = g;
                    m_cnt[d]   = 1;
                    if (bur[d] > 1) m_hold[d] = 1'b1;
                    else            m_ptr[d]  = (g + 1) % K;
                end
                m_ov[d] = (g >= 0);
                if (g >= 0) begin
                    m_od[d]   = rd[g];
                    m_odst[d] = rdst[g];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst  = 1'b1;
        rv   = '0;
        ordy = 1'b1;
        cycle();
        cycle();
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        rv   = '1;
        ordy = 1'b1;
        rand_flits();
        cycle();
        cycle();
        rst = 1'b0;
        tests++;
        if (if1.out_valid !== 1'b0 || if1.out_data !== '0 || if1.out_dest !== '0) begin
            fails++;
            $display("FAIL reset_out dut1: got v=%b d=%h a=%0d want 0/0/0", if1.out_valid, if1.out_data, if1.out_dest);
        end
        tests++;
        if (if4.out_valid !== 1'b0 || if4.out_data !== '0 || if4.out_dest !== '0) begin
            fails++;
            $display("FAIL reset_out dut4: got v=%b d=%h a=%0d want 0/0/0", if4.out_valid, if4.out_data, if4.out_dest);
        end
    endtask

    task automatic test_order();
        int e1 [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        int e4 [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
        apply_reset();
        rv   = '1;
        ordy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rand_flits();
            cycle();
            tests++;
            if (obs_g[0] !== e1[i]) begin
                fails++;
                $display("FAIL order_b1 step %0d: got %0d want %0d", i, obs_g[0], e1[i]);
            end
            tests++;
            if (obs_g[1] !== e4[i]) begin
                fails++;
                $display("FAIL order_b4 step %0d: got %0d want %0d", i, obs_g[1], e4[i]);
            end
        end
    endtask

    task automatic test_burst_drop();
        int e4 [8] = '{0, 0, 0, 0, 1, 1, -1, 2};
        apply_reset();
        ordy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rv = (i >= 6) ? 4'b1101 : 4'b1111;
            rand_flits();
            cycle();
            tests++;
            if (obs_g[1] !== e4[i]) begin
                fails++;
                $display("FAIL burst_drop step %0d: got %0d want %0d", i, obs_g[1], e4[i]);
            end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        rv      = 4'b0001;
        rd[0]   = 32'hA5A5A5A5;
        rdst[0] = 4'd7;
        ordy    = 1'b0;
        cycle();
        rv = '1;
        for (int i = 0; i < 5; i++) begin
            rand_flits();
            cycle();
            tests++;
            if (if1.out_valid !== 1'b1 || if1.out_data !== 32'hA5A5A5A5 || if1.out_dest !== 4'd7 ||
                if4.out_valid !== 1'b1 || if4.out_data !== 32'hA5A5A5A5 || if4.out_dest !== 4'd7) begin
                fails++;
                $display("FAIL stall_hold %0d: got %h/%0d %h/%0d want a5a5a5a5/7", i,
                         if1.out_data, if1.out_dest, if4.out_data, if4.out_dest);
            end
            tests++;
            if (if1.req_ready !== '0 || if4.req_ready !== '0) begin
                fails++;
                $display("FAIL stall_ready %0d: got %b %b want 0000", i, if1.req_ready, if4.req_ready);
            end
        end
        ordy = 1'b1;
        rv   = '0;
        cycle();
        tests++;
        if (if1.out_valid !== 1'b0 || if4.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_once: got out_valid %b %b want 0 0", if1.out_valid, if4.out_valid);
        end
    endtask

    task automatic test_single_and_reset();
        apply_reset();
        rv   = 4'b1000;
        ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_flits();
            cycle();
            tests++;
            if (obs_g[0] !== 3 || obs_g[1] !== 3) begin
                fails++;
                $display("FAIL single3 step %0d: got %0d %0d want 3 3", i, obs_g[0], obs_g[1]);
            end
        end
        rv = 4'b1001;
        cycle();
        tests++;
        if (obs_g[0] !== 0 || obs_g[1] !== 0) begin
            fails++;
            $display("FAIL ptr_wrap: got %0d %0d want 0 0", obs_g[0], obs_g[1]);
        end
        rv   = '1;
        ordy = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        tests++;
        if (if1.out_valid !== 1'b0 || if4.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_discard: got out_valid %b %b want 0 0", if1.out_valid, if4.out_valid);
        end
        rv   = 4'b0110;
        ordy = 1'b1;
        cycle();
        tests++;
        if (obs_g[0] !== 1 || obs_g[1] !== 1) begin
            fails++;
            $display("FAIL post_rst_grant: got %0d %0d want 1 1", obs_g[0], obs_g[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rv   = K'($urandom_range(0, 15));
            ordy = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 199) == 0);
            rand_flits();
            cycle();
        end
        rst = 1'b0;
    endtask

`ifdef SRC_ARBITER_STATS_EN
    task automatic test_stats();
        apply_reset();
        rv   = 4'b0100;
        ordy = 1'b1;
        ssel = 2'd2;
        repeat (70000) @(negedge clk);
        #1;
        tests++;
        if (scnt1 !== 16'hFFFF || scnt4 !== 16'hFFFF) begin
            fails++;
            $display("FAIL stats_sat: got %0d %0d want 65535", scnt1, scnt4);
        end
        for (int s = 0; s < K; s++) begin
            if (s == 2) continue;
            ssel = s[1:0];
            #1;
            tests++;
            if (scnt1 !== 16'd0 || scnt4 !== 16'd0) begin
                fails++;
                $display("FAIL stats_other sel=%0d: got %0d %0d want 0", s, scnt1, scnt4);
            end
        end
        // Model was not stepped during the long run; resynchronise through a quiet reset.
        rv  = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset(0);
        model_reset(1);
        rst = 1'b0;
    endtask
`endif

    initial begin
        rst  = 1'b1;
        rv   = '0;
        ordy = 1'b0;
`ifdef SRC_ARBITER_STATS_EN
        ssel = '0;
`endif
        rand_flits();
        repeat (2) @(negedge clk);
        model_reset(0);
        model_reset(1);

        test_reset();
        test_order();
        test_burst_drop();
        test_stall();
        test_single_and_reset();
        test_random();
`ifdef SRC_ARBITER_STATS_EN
        test_stats();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
